// File: rtl/rx_word_sync_ctrl.sv
// RX word-boundary hunt, comma/error sync FSM and invalid code-group counter
// sitting between the deserializer and the 8b/10b decoder.
module rx_word_sync_ctrl #(
  parameter int unsigned SLIP_WAIT       = 20,
  parameter int unsigned SLIP_SETTLE     = 4,
  parameter int unsigned GOOD_TO_RECOVER = 4,
  parameter int unsigned ERR_CNT_W       = 16
) (
  input  logic                 BitCLK_10,
  input  logic                 Reset,
  input  logic [9:0]           RxParallel_10,
  input  logic                 Decode_Error,
  input  logic                 Disparity_Error,
  input  logic                 Err_Clear,
  output logic                 Bit_Slip,
  output logic                 Sync_Acquired,
  output logic [2:0]           Link_State,
  output logic [ERR_CNT_W-1:0] Err_Count
);

  localparam int GapW    = $clog2(SLIP_WAIT + 2);
  localparam int SettleW = $clog2(SLIP_SETTLE + 2);
  localparam int GoodW   = $clog2(GOOD_TO_RECOVER + 2);

  localparam logic [GapW-1:0]    GapLast    = GapW'(SLIP_WAIT - 1);
  localparam logic [SettleW-1:0] SettleInit = SettleW'(SLIP_SETTLE);
  localparam logic [GoodW-1:0]   GoodLast   = GoodW'(GOOD_TO_RECOVER - 1);

  localparam logic [9:0] CommaNeg = 10'b0011111010;
  localparam logic [9:0] CommaPos = 10'b1100000101;

  typedef enum logic [2:0] {
    StLos  = 3'd0,
    StDet1 = 3'd1,
    StDet2 = 3'd2,
    StSync = 3'd3,
    StErr1 = 3'd4,
    StErr2 = 3'd5,
    StErr3 = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic [SettleW-1:0]     settle_q, settle_d;
  logic [GoodW-1:0]       good_q, good_d;
  logic                   slip_q, slip_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic invalid, valid_comma, in_sync;

  assign invalid     = Decode_Error | Disparity_Error;
  assign valid_comma = ((RxParallel_10 == CommaNeg) || (RxParallel_10 == CommaPos)) && !invalid;
  assign in_sync     = (state_q == StSync) || (state_q == StErr1) ||
                       (state_q == StErr2) || (state_q == StErr3);

  always_ff @(posedge BitCLK_10 or posedge Reset) begin
    if (Reset) begin
      state_q   <= StLos;
      gap_q     <= '0;
      settle_q  <= '0;
      good_q    <= '0;
      slip_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      settle_q  <= settle_d;
      good_q    <= good_d;
      slip_q    <= slip_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    settle_d  = settle_q;
    good_d    = good_q;
    slip_d    = 1'b0;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      StLos: begin
        // Words arriving while the deserializer realigns carry no information.
        if (settle_q != '0) begin
          settle_d = settle_q - 1'b1;
        end else if (valid_comma) begin
          state_d = StDet1;
          gap_d   = '0;
        end else if (gap_q == GapLast) begin
          slip_d   = 1'b1;
          gap_d    = '0;
          settle_d = SettleInit;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StDet1, StDet2: begin
        if (invalid) begin
          state_d = StLos;
          gap_d   = '0;
        end else if (valid_comma) begin
          state_d = (state_q == StDet1) ? StDet2 : StSync;
          gap_d   = '0;
        end else if (gap_q == GapLast) begin
          state_d = StLos;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StSync: begin
        if (invalid) begin
          state_d = StErr1;
          good_d  = '0;
        end
      end
      StErr1, StErr2, StErr3: begin
        if (invalid) begin
          state_d = (state_q == StErr3) ? StLos : state_e'(state_q + 3'd1);
          good_d  = '0;
        end else if (good_q == GoodLast) begin
          // Encoding places SYNC directly below ERR_1, so stepping down is a decrement.
          state_d = state_e'(state_q - 3'd1);
          good_d  = '0;
        end else begin
          good_d = good_q + 1'b1;
        end
      end
      default: begin
        state_d = StLos;
        gap_d   = '0;
        good_d  = '0;
      end
    endcase

    if (Err_Clear) begin
      err_cnt_d = (invalid && in_sync) ? ERR_CNT_W'(1) : '0;
    end else if (invalid && in_sync && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  assign Bit_Slip      = slip_q;
  assign Sync_Acquired = in_sync;
  assign Link_State    = state_q;
  assign Err_Count     = err_cnt_q;

endmodule

// File: tb/tb_rx_word_sync_ctrl.sv
// Directed bench for rx_word_sync_ctrl: a default instance plus a 4-bit
// error-counter instance sharing the same stimulus.
module tb_rx_word_sync_ctrl;

  localparam logic [9:0] K = 10'b0011111010;
  localparam logic [9:0] D = 10'b1010101010;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rx;
  logic        dec, disp, clr;
  logic        slip, sync;
  logic [2:0]  state;
  logic [15:0] cnt;
  logic        slip4, sync4;
  logic [2:0]  state4;
  logic [3:0]  cnt4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rx_word_sync_ctrl dut (
    .BitCLK_10(clk), .Reset(rst), .RxParallel_10(rx), .Decode_Error(dec),
    .Disparity_Error(disp), .Err_Clear(clr), .Bit_Slip(slip), .Sync_Acquired(sync),
    .Link_State(state), .Err_Count(cnt)
  );

  rx_word_sync_ctrl #(.ERR_CNT_W(4)) dut4 (
    .BitCLK_10(clk), .Reset(rst), .RxParallel_10(rx), .Decode_Error(dec),
    .Disparity_Error(disp), .Err_Clear(clr), .Bit_Slip(slip4), .Sync_Acquired(sync4),
    .Link_State(state4), .Err_Count(cnt4)
  );

  task automatic word(input logic [9:0] d, input logic de, input logic di);
    rx   = d;
    dec  = de;
    disp = di;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx  = D; dec = 1'b0; disp = 1'b0; clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic go_sync();
    do_reset();
    word(K, 0, 0);
    word(K, 0, 0);
    word(K, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (sync !== 1'b0) begin errors++; $display("FAIL reset_sync got %0b want 0", sync); end
    checks++; if (slip !== 1'b0) begin errors++; $display("FAIL reset_slip got %0b want 0", slip); end
    checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    checks++; if ({slip4, sync4, state4, cnt4} !== 9'd0) begin
      errors++; $display("FAIL reset_w4 got %0h want 0", {slip4, sync4, state4, cnt4});
    end
  endtask

  task automatic test_reset_mid();
    go_sync();
    for (int r = 0; r < 5; r++) begin
      word(D, 1, 0);
      for (int g = 0; g < 4; g++) word(D, 0, 0);
    end
    word(D, 1, 0);
    word(D, 0, 1);
    checks++; if (state !== 3'd5 || cnt !== 16'd7) begin
      errors++; $display("FAIL mid_pre got state=%0d cnt=%0d want 5/7", state, cnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (state !== 3'd0 || sync !== 1'b0 || cnt !== 16'd0 || slip !== 1'b0) begin
      errors++; $display("FAIL mid_reset got state=%0d sync=%0b cnt=%0d slip=%0b want 0/0/0/0",
                         state, sync, cnt, slip);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_acquire();
    int slips = 0;
    do_reset();
    for (int e = 1; e <= 11; e++) begin
      word((e == 1 || e == 6 || e == 11) ? K : D, 0, 0);
      if (slip) slips++;
      if (e == 1 || e == 5 || e == 6 || e == 10 || e == 11) begin
        logic [2:0] exp;
        exp = (e < 6) ? 3'd1 : (e < 11) ? 3'd2 : 3'd3;
        checks++; if (state !== exp) begin
          errors++; $display("FAIL acq_state edge %0d got %0d want %0d", e, state, exp);
        end
      end
    end
    checks++; if (sync !== 1'b1) begin errors++; $display("FAIL acq_sync got %0b want 1", sync); end
    checks++; if (slips !== 0) begin errors++; $display("FAIL acq_noslip got %0d want 0", slips); end
  endtask

  task automatic test_slip_hunt();
    int bad = 0;
    do_reset();
    for (int e = 1; e <= 68; e++) begin
      word(D, 0, 0);
      if (slip !== (e == 20 || e == 44 || e == 68)) begin
        bad++; $display("FAIL slip_edge %0d got %0b want %0b", e, slip, (e == 20 || e == 44 || e == 68));
      end
    end
    checks++; if (bad != 0) errors++;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL slip_state got %0d want 0", state); end
    do_reset();
    for (int e = 1; e <= 49; e++) word(D, 0, 0);
    word(K, 0, 0);
    checks++; if (state !== 3'd1 || slip !== 1'b0) begin
      errors++; $display("FAIL slip_comma got state=%0d slip=%0b want 1/0", state, slip);
    end
  endtask

  task automatic test_error_ladder();
    go_sync();
    word(D, 1, 0);
    checks++; if (state !== 3'd4 || cnt !== 16'd1) begin
      errors++; $display("FAIL ladder_err1 got %0d/%0d want 4/1", state, cnt);
    end
    for (int g = 0; g < 3; g++) word(D, 0, 0);
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL ladder_hold got %0d want 4", state); end
    word(D, 0, 0);
    checks++; if (state !== 3'd3 || cnt !== 16'd1) begin
      errors++; $display("FAIL ladder_recover got %0d/%0d want 3/1", state, cnt);
    end
    for (int i = 0; i < 4; i++) begin
      logic [2:0] exp;
      exp = (i == 3) ? 3'd0 : 3'(4 + i);
      word(K, 0, 1);
      checks++; if (state !== exp) begin
        errors++; $display("FAIL ladder_step %0d got %0d want %0d", i, state, exp);
      end
    end
    checks++; if (cnt !== 16'd5 || sync !== 1'b0) begin
      errors++; $display("FAIL ladder_end got cnt=%0d sync=%0b want 5/0", cnt, sync);
    end
    word(D, 1, 0);
    checks++; if (cnt !== 16'd5) begin errors++; $display("FAIL ladder_los_nocount got %0d want 5", cnt); end
  endtask

  task automatic test_abort_detect();
    int slips = 0;
    do_reset();
    word(K, 0, 0);
    word(K, 0, 1);
    checks++; if (state !== 3'd0 || cnt !== 16'd0) begin
      errors++; $display("FAIL abort_det1 got %0d/%0d want 0/0", state, cnt);
    end
    word(K, 0, 0);
    word(K, 0, 0);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL abort_det2 got %0d want 2", state); end
    for (int i = 1; i <= 19; i++) begin word(D, 0, 0); if (slip) slips++; end
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL abort_hold got %0d want 2", state); end
    word(D, 0, 0); if (slip) slips++;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL abort_gap got %0d want 0", state); end
    word(D, 0, 0); if (slip) slips++;
    checks++; if (slips !== 0) begin errors++; $display("FAIL abort_noslip got %0d want 0", slips); end
  endtask

  task automatic test_err_saturate();
    go_sync();
    for (int r = 0; r < 20; r++) begin
      word(D, 1, 0);
      for (int g = 0; g < 4; g++) word(D, 0, 0);
    end
    checks++; if (cnt4 !== 4'd15) begin errors++; $display("FAIL sat_w4 got %0d want 15", cnt4); end
    checks++; if (cnt !== 16'd20) begin errors++; $display("FAIL sat_w16 got %0d want 20", cnt); end
    checks++; if (state4 !== 3'd3) begin errors++; $display("FAIL sat_state got %0d want 3", state4); end
    clr = 1'b1;
    word(D, 1, 0);
    checks++; if (cnt4 !== 4'd1 || cnt !== 16'd1) begin
      errors++; $display("FAIL clr_invalid got %0d/%0d want 1/1", cnt4, cnt);
    end
    word(D, 0, 0);
    clr = 1'b0;
    checks++; if (cnt4 !== 4'd0) begin errors++; $display("FAIL clr_valid got %0d want 0", cnt4); end
  endtask

  initial begin
    rst = 1'b1; rx = D; dec = 1'b0; disp = 1'b0; clr = 1'b0;
    test_reset();
    test_reset_mid();
    test_acquire();
    test_slip_hunt();
    test_error_ladder();
    test_abort_detect();
    test_err_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_word_sync_ctrl.md
# rx_word_sync_ctrl

Receive-side link synchronization controller for the SerDes RX path. Sits between the deserializer and the 8b/10b decoder on the 10-bit word clock. It does three things:
- hunts for K28.5 commas and steps the deserializer word boundary with single-cycle slip pulses until commas appear;
- runs a comma/error sync state machine that decides when decoded data is trustworthy;
- counts invalid code-groups (decode or disparity errors) reported by the decoder while synchronized.

## Interface

Parameters:
- SLIP_WAIT, 20, consecutive non-comma words counted in LOS before a slip is issued; also the max word gap between commas in COMMA_DET states.
- SLIP_SETTLE, 4, words ignored after each slip pulse while the deserializer realigns.
- GOOD_TO_RECOVER, 4, consecutive valid words needed to step back one error level.
- ERR_CNT_W, 16, width of Err_Count.

Ports:
- BitCLK_10  in  1  word clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- RxParallel_10  in  10  current 10-bit code-group from the deserializer.
- Decode_Error  in  1  decoder flags the current word as an invalid code-group; same cycle as the word.
- Disparity_Error  in  1  decoder flags a running-disparity violation on the current word; same cycle as the word.
- Err_Clear  in  1  synchronous clear of Err_Count.
- Bit_Slip  out  1  one-cycle pulse; the deserializer shifts its word boundary by one bit.
- Sync_Acquired  out  1  high in SYNC, ERR_1, ERR_2 and ERR_3.
- Link_State  out  3  encoding: LOS=0, DET_1=1, DET_2=2, SYNC=3, ERR_1=4, ERR_2=5, ERR_3=6.
- Err_Count  out  ERR_CNT_W  saturating count of invalid words while Sync_Acquired is high.

## Operation

Word classification:
- comma = RxParallel_10 equals 10'b0011111010 or 10'b1100000101.
- invalid = Decode_Error OR Disparity_Error.
- A comma that is also invalid counts as invalid only.

Word counter (gap counter):
- Counts in LOS and in DET_1/DET_2.
- Cleared on a valid comma, on every state change, and on every slip.

LOS:
- Valid comma -> DET_1.
- Otherwise the gap counter increments. On the SLIP_WAIT-th consecutive non-comma word:
  - Bit_Slip = 1 for the next cycle;
  - gap counter cleared;
  - settle counter loaded with SLIP_SETTLE.
- While settle > 0: words are ignored entirely (no comma detection, no counting); settle decrements once per word.

DET_1 / DET_2:
- Invalid word -> LOS.
- Valid comma -> next state (DET_1 -> DET_2, DET_2 -> SYNC).
- SLIP_WAIT consecutive valid non-comma words -> LOS. No slip is issued on this transition.

SYNC:
- Invalid word -> ERR_1; good counter cleared.

ERR_n:
- Invalid word -> ERR_(n+1), or LOS from ERR_3; good counter cleared.
- Valid word -> good counter increments. At GOOD_TO_RECOVER: step to ERR_(n-1), or SYNC from ERR_1; good counter cleared.

Err_Count:
- +1 on each invalid word sampled while Sync_Acquired is high, including the word that causes ERR_3 -> LOS.
- Saturates at all-ones.
- Err_Clear has priority: Err_Clear together with an invalid word in sync -> 1; otherwise -> 0.

Reset (asynchronous, any state, mid-slip or mid-settle):
- Link_State = LOS, Sync_Acquired = 0, Bit_Slip = 0, Err_Count = 0.
- All internal counters = 0.

## Timing

- All outputs are registered. The word sampled at edge k is reflected in the outputs after edge k (one-cycle latency); no combinational input-to-output path.
- Bit_Slip is high for exactly one cycle and never in two consecutive cycles.
- With no commas, slip pulses repeat every SLIP_WAIT+SLIP_SETTLE cycles. First pulse is visible after the SLIP_WAIT-th word edge.
- Sync_Acquired rises at the edge that samples the third valid comma (DET_2 -> SYNC).
- Sync_Acquired falls at the edge that samples the fourth invalid word of an unrecovered burst (ERR_3 -> LOS).
- Reset deassertion: the first word is evaluated at the first rising edge after release.

## Test plan

- Reset mid-operation: assert Reset while in ERR_2 with Err_Count=7 -> immediately Link_State=0, Sync_Acquired=0, Err_Count=0, Bit_Slip=0.
- Acquisition: valid K28.5 at edges 1, 6, 11, valid data between -> Link_State 1 after edge 1, 2 after edge 6, 3 after edge 11; Bit_Slip never asserted.
- Slip hunt (defaults): 60 valid non-comma words from reset -> Bit_Slip high only in the cycles after edges 20 and 44; then a comma at edge 50 -> DET_1.
- Error ladder: in SYNC, one invalid word then 4 valid -> ERR_1 then SYNC, Err_Count=1. Then 4 consecutive invalid -> ERR_1, ERR_2, ERR_3, LOS; Err_Count=5; Sync_Acquired low after the 4th.
- Abort in detect: DET_1 then a word with Disparity_Error=1 -> LOS, no count change. DET_2 with 20 non-comma words -> LOS, no slip.
- Counter edges with ERR_CNT_W=4: 20 invalid words spread across ERR_1/SYNC recoveries -> Err_Count holds 15. Err_Clear together with an invalid word -> 1.
